pipeline_hazard_ctrl: RTL and testbench

//  Generates enable/flush controls for the PC, fetch-to-decode, decode-to-execute and execute-to-memory registers.

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a classic five-stage pipeline. It decides, every
// cycle, which of the PC, F/D, D/X and X/M registers load new data and which
// load a bubble. It covers load-use hazards, multi-cycle MUL, taken
// branch/jump redirects, and instruction/data cache misses. It holds only
// control state (miss FSM, return state and MUL occupancy counter), never
// datapath values.
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_src_reg_1,
  input  logic [4:0] d_src_reg_2,
  input  logic       d_uses_src_2,
  input  logic [4:0] x_dst_reg,
  input  logic       x_mem_read,
  input  logic       x_is_mul,
  input  logic       x_branch_taken,
  input  logic       i_miss,
  input  logic       i_ready,
  input  logic       d_miss,
  input  logic       d_ready,
  output logic       pc_enable,
  output logic       f_d_enable,
  output logic       f_d_flush,
  output logic       d_x_enable,
  output logic       d_x_flush,
  output logic       x_m_enable,
  output logic       x_m_flush,
  output logic       i_abort,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } state_e;

  // A single-cycle MUL never needs the counter. Otherwise the counter starts
  // at LATENCY-2, so that the countdown plus the start cycle gives LATENCY-1
  // stall cycles before the release cycle.
  localparam logic     MUL_EN       = (MUL_LATENCY > 1);
  localparam int       MUL_INIT_INT = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [3:0] MUL_INIT   = MUL_INIT_INT[3:0];

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic       mul_busy_q, mul_busy_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;

  logic freeze;
  logic load_use;
  logic mul_stall;
  logic fetch_wait;

  // Hazard detection terms derived from the current registers and inputs
  always_comb begin
    freeze     = d_miss | (state_q == DMISS);
    load_use   = d_valid & x_mem_read & (x_dst_reg != 5'd0) &
                 ((x_dst_reg == d_src_reg_1) |
                  (d_uses_src_2 & (x_dst_reg == d_src_reg_2)));
    mul_stall  = MUL_EN & ((!mul_busy_q & x_is_mul) |
                           (mul_busy_q & (mul_cnt_q != 4'd0)));
    fetch_wait = ((state_q == RUN) & i_miss) |
                 ((state_q == IMISS) & !i_ready);
  end

  // Prioritised enable/flush generation; the highest-priority active hazard wins
  always_comb begin
    pc_enable  = 1'b1;
    f_d_enable = 1'b1;
    f_d_flush  = 1'b0;
    d_x_enable = 1'b1;
    d_x_flush  = 1'b0;
    x_m_enable = 1'b1;
    x_m_flush  = 1'b0;
    i_abort    = 1'b0;
    if (reset) begin
      f_d_flush = 1'b1;
      d_x_flush = 1'b1;
      x_m_flush = 1'b1;
    end else if (freeze) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_x_enable = 1'b0;
      x_m_enable = 1'b0;
    end else if (x_branch_taken) begin
      f_d_flush = 1'b1;
      d_x_flush = 1'b1;
      i_abort   = (state_q == IMISS) | i_miss;
    end else if (mul_stall) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_x_enable = 1'b0;
      x_m_flush  = 1'b1;
    end else if (load_use) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_x_flush  = 1'b1;
    end else if (fetch_wait) begin
      pc_enable = 1'b0;
      f_d_flush = 1'b1;
    end
    ctrl_state = state_q;
  end

  // Miss FSM next state; a data miss overrides everything, a branch cancels an instruction miss
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      RUN: begin
        if (d_miss) begin
          state_d = DMISS;
          ret_d   = RUN;
        end else if (i_miss & !x_branch_taken) begin
          state_d = IMISS;
        end
      end
      IMISS: begin
        if (d_miss) begin
          state_d = DMISS;
          ret_d   = IMISS;
        end else if (x_branch_taken) begin
          state_d = RUN;
        end else if (i_ready & !mul_stall & !load_use) begin
          state_d = RUN;
        end
      end
      DMISS: begin
        if (d_ready) begin
          state_d = ret_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // MUL occupancy counter; it stands still while the pipeline is frozen
  always_comb begin
    mul_busy_d = mul_busy_q;
    mul_cnt_d  = mul_cnt_q;
    if (!freeze) begin
      if (!mul_busy_q & x_is_mul & MUL_EN) begin
        mul_busy_d = 1'b1;
        mul_cnt_d  = MUL_INIT;
      end else if (mul_busy_q & (mul_cnt_q != 4'd0)) begin
        mul_cnt_d = mul_cnt_q - 4'd1;
      end else if (mul_busy_q) begin
        mul_busy_d = 1'b0;
      end
    end
  end

  // Control registers; reset abandons any miss or MUL in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      ret_q      <= RUN;
      mul_busy_q <= 1'b0;
      mul_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mul_busy_q <= mul_busy_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl with MUL_LATENCY=5.
// A table of per-cycle input/expected-output rows is applied in order. The
// rows include a random-length data-miss sequence added at the end. Each
// expected value is queued when its stimulus is driven and is checked half a
// cycle later.
module tb_pipeline_hazard_ctrl;

  // Output bit order: pc_en fd_en fd_fl dx_en dx_fl xm_en xm_fl i_abort
  localparam logic [7:0] O_NORM  = 8'b1101_0100;
  localparam logic [7:0] O_RST   = 8'b1111_1110;
  localparam logic [7:0] O_FRZ   = 8'b0000_0000;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_BRAB  = 8'b1111_1101;
  localparam logic [7:0] O_MUL   = 8'b0000_0110;
  localparam logic [7:0] O_LU    = 8'b0001_1100;
  localparam logic [7:0] O_FW    = 8'b0111_0100;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       u2;
    logic [4:0] xd;
    logic       mr;
    logic       mul;
    logic       br;
    logic       im;
    logic       ir;
    logic       dm;
    logic       dr;
    logic [7:0] expOut;
    logic [1:0] expSt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] o;
    logic [1:0] s;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, d_valid, d_uses_src_2, x_mem_read, x_is_mul;
  logic       x_branch_taken, i_miss, i_ready, d_miss, d_ready;
  logic [4:0] d_src_reg_1, d_src_reg_2, x_dst_reg;
  logic       pc_enable, f_d_enable, f_d_flush, d_x_enable, d_x_flush;
  logic       x_m_enable, x_m_flush, i_abort;
  logic [1:0] ctrl_state;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectorCount = 0;
  int   missCount   = 0;

  pipeline_hazard_ctrl #(.MUL_LATENCY(5)) dut (
    .clock(clock), .reset(reset), .d_valid(d_valid),
    .d_src_reg_1(d_src_reg_1), .d_src_reg_2(d_src_reg_2),
    .d_uses_src_2(d_uses_src_2), .x_dst_reg(x_dst_reg),
    .x_mem_read(x_mem_read), .x_is_mul(x_is_mul),
    .x_branch_taken(x_branch_taken), .i_miss(i_miss), .i_ready(i_ready),
    .d_miss(d_miss), .d_ready(d_ready), .pc_enable(pc_enable),
    .f_d_enable(f_d_enable), .f_d_flush(f_d_flush),
    .d_x_enable(d_x_enable), .d_x_flush(d_x_flush),
    .x_m_enable(x_m_enable), .x_m_flush(x_m_flush), .i_abort(i_abort),
    .ctrl_state(ctrl_state)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic dv, input logic [4:0] s1,
                              input logic [4:0] s2, input logic u2, input logic [4:0] xd,
                              input logic mr, input logic mul, input logic br,
                              input logic im, input logic ir, input logic dm,
                              input logic dr, input logic [7:0] eo, input logic [1:0] es);
    vec_t v;
    v.rst = rst; v.dv = dv; v.s1 = s1; v.s2 = s2; v.u2 = u2; v.xd = xd;
    v.mr = mr; v.mul = mul; v.br = br; v.im = im; v.ir = ir; v.dm = dm;
    v.dr = dr; v.expOut = eo; v.expSt = es;
    return v;
  endfunction

  // Convenience: a row with only control-type inputs set
  function automatic vec_t ctl(input logic rst, input logic mul, input logic br,
                               input logic im, input logic ir, input logic dm,
                               input logic dr, input logic [7:0] eo, input logic [1:0] es);
    return mk(rst, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, mul, br, im, ir, dm, dr, eo, es);
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(posedge clock);
    #1;
    reset = v.rst; d_valid = v.dv; d_src_reg_1 = v.s1; d_src_reg_2 = v.s2;
    d_uses_src_2 = v.u2; x_dst_reg = v.xd; x_mem_read = v.mr; x_is_mul = v.mul;
    x_branch_taken = v.br; i_miss = v.im; i_ready = v.ir; d_miss = v.dm;
    d_ready = v.dr;
    e.idx = idx; e.o = v.expOut; e.s = v.expSt;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] got;
    @(negedge clock);
    vectorCount++;
    if (sb.size() == 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing to compare, required one entry");
    end else begin
      e   = sb.pop_front();
      got = {pc_enable, f_d_enable, f_d_flush, d_x_enable, d_x_flush,
             x_m_enable, x_m_flush, i_abort};
      if (got !== e.o || ctrl_state !== e.s) begin
        missCount++;
        $display("[TB] FAIL vec%0d: got out=%b state=%0d, required out=%b state=%0d",
                 e.idx, got, ctrl_state, e.o, e.s);
      end
    end
  endtask

  initial begin
    int n;
    int idx;
    reset = 1'b1; d_valid = 1'b0; d_src_reg_1 = 5'd0; d_src_reg_2 = 5'd0;
    d_uses_src_2 = 1'b0; x_dst_reg = 5'd0; x_mem_read = 1'b0; x_is_mul = 1'b0;
    x_branch_taken = 1'b0; i_miss = 1'b0; i_ready = 1'b0; d_miss = 1'b0;
    d_ready = 1'b0;
    repeat (2) @(posedge clock);

    //            rst dv s1    s2    u2 xd    mr mul br im ir dm dr exp     st
    vecs.push_back(ctl(1, 0, 0, 0, 0, 0, 0, O_RST, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Load-use on src1, then the load has left execute
    vecs.push_back(mk(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0, O_LU, 2'd0));
    vecs.push_back(mk(0, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Load to x0 never stalls
    vecs.push_back(mk(0, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // src2 match only counts when src2 is read
    vecs.push_back(mk(0, 1, 5'd1, 5'd7, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    vecs.push_back(mk(0, 1, 5'd1, 5'd7, 1, 5'd7, 1, 0, 0, 0, 0, 0, 0, O_LU, 2'd0));
    // No real instruction in decode
    vecs.push_back(mk(0, 0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // MUL held: four stall cycles then the release cycle
    for (int i = 0; i < 4; i++) vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_MUL, 2'd0));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // MUL interrupted by a data miss on its second stall cycle
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_MUL, 2'd0));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 1, 0, O_FRZ, 2'd0));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_FRZ, 2'd2));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_FRZ, 2'd2));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 1, O_FRZ, 2'd2));
    for (int i = 0; i < 3; i++) vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_MUL, 2'd0));
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Instruction miss, then branch aborts the fetch
    vecs.push_back(ctl(0, 0, 0, 1, 0, 0, 0, O_FW, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 1, 0, 0, 0, O_FW, 2'd1));
    vecs.push_back(ctl(0, 0, 1, 0, 0, 0, 0, O_BRAB, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Branch in RUN, with and without a same-cycle icache miss
    vecs.push_back(ctl(0, 0, 1, 0, 0, 0, 0, O_BR, 2'd0));
    vecs.push_back(ctl(0, 0, 1, 1, 0, 0, 0, O_BRAB, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Refill done while a load-use holds decode: stay in IMISS one more cycle
    vecs.push_back(ctl(0, 0, 0, 1, 0, 0, 0, O_FW, 2'd0));
    vecs.push_back(mk(0, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 0, 1, 0, 0, O_LU, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 1, 0, 0, O_NORM, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Data miss during IMISS returns to IMISS
    vecs.push_back(ctl(0, 0, 0, 1, 0, 0, 0, O_FW, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 1, 0, O_FRZ, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 1, O_FRZ, 2'd2));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_FW, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 1, 0, 0, O_NORM, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Reset during DMISS
    vecs.push_back(ctl(0, 0, 0, 0, 0, 1, 0, O_FRZ, 2'd0));
    vecs.push_back(ctl(1, 0, 0, 0, 0, 0, 0, O_RST, 2'd2));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Reset mid-MUL clears the counter
    vecs.push_back(ctl(0, 1, 0, 0, 0, 0, 0, O_MUL, 2'd0));
    vecs.push_back(ctl(1, 1, 0, 0, 0, 0, 0, O_RST, 2'd0));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));
    // Reset during IMISS with a branch: no abort pulse
    vecs.push_back(ctl(0, 0, 0, 1, 0, 0, 0, O_FW, 2'd0));
    vecs.push_back(ctl(1, 0, 1, 0, 0, 0, 0, O_RST, 2'd1));
    vecs.push_back(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
      checkOutput();
    end

    // Hand-written sequences: data misses of random length from RUN
    idx = 1000;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 6);
      applyStimulus(ctl(0, 0, 0, 0, 0, 1, 0, O_FRZ, 2'd0), idx++);
      checkOutput();
      for (int j = 0; j < n; j++) begin
        applyStimulus(ctl(0, 0, 1, 1, 0, 0, 0, O_FRZ, 2'd2), idx++);
        checkOutput();
      end
      applyStimulus(ctl(0, 0, 0, 0, 0, 0, 1, O_FRZ, 2'd2), idx++);
      checkOutput();
      applyStimulus(ctl(0, 0, 0, 0, 0, 0, 0, O_NORM, 2'd0), idx++);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
